machine_scan: RTL
=================

Name: machine_scan

Overview:
- Display-scan state generator; sits directly upstream of the seven-segment render stage.
- Holds four 4-bit digit codes and rotates an active-low one-hot anode select at a programmable slot rate.
- Emits the 20-bit packed display state that the render stage consumes each cycle.
- New digit sets arrive through a valid/ready handshake. They are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- PRESCALE, 50000: clock cycles per digit slot (1 ms at 50 MHz). Legal values are 2 or more; the implementation carries an elaboration-time check.
- CNT_W, 16: prescaler counter width. Must satisfy 2^CNT_W >= PRESCALE.

Ports:
- system1000  in  1: clock. All logic is on the rising edge.
- system1000_rstn  in  1: synchronous, active-low reset.
- in_valid  in  1: a digit set is offered on in_digits.
- in_ready  out  1: the block can accept a digit set.
- in_digits  in  16: {digit0, digit1, digit2, digit3}, 4 bits each; digit0 is in [15:12].
- frame_start  out  1: one-cycle pulse when the scan wraps from slot 3 to slot 0.
- state  out  20: {digit0, digit1, digit2, digit3, anode_n[3:0]}, feeding the render stage.

Behaviour:
- Anode encoding (active-low one-hot):
  - slot0 = 4'b1110, slot1 = 4'b1101, slot2 = 4'b1011, slot3 = 4'b0111.
  - 4'b1111 means blank; it is only produced by the optional feature.
- Prescaler:
  - cnt counts 0..PRESCALE-1; tc = (cnt == PRESCALE-1).
  - On tc, cnt goes to 0 and slot advances by one, wrapping 3 -> 0.
- state is registered:
  - Digit fields always come from the active register.
  - anode_n is decoded from slot and registered in the same cycle slot updates, so state changes exactly one cycle after tc.
- Handshake:
  - A transfer occurs when in_valid && in_ready on a rising edge; in_digits is then captured into the pending register and pend_v is set.
  - in_ready = !pend_v && system1000_rstn; it is low while reset is asserted.
  - in_valid may be held high; data on non-transfer cycles is ignored.
- Commit:
  - Applies on the tc edge where slot == 3 (the frame wrap): if pend_v, active <= pending and pend_v is cleared.
  - The new digits and slot0 anode appear in state on the same cycle.
- frame_start is registered and is high for exactly the one cycle in which state first shows slot0 of a new frame.
- Simultaneous transfer and commit: cannot occur, because a commit requires pend_v = 1, which forces in_ready = 0.
- Transfer on the frame-wrap cycle with pend_v = 0: data goes to pending and commits at the next wrap. There is no bypass.
- Reset values (on an edge with system1000_rstn = 0):
  - cnt = 0, slot = 0, active = 16'h0000, pending = 16'h0000, pend_v = 0.
  - state = 20'h0000E, frame_start = 0, in_ready = 0.
- Reset mid-frame or with a pending set: the pending set is discarded and scanning restarts at slot0 with cnt = 0.
- Frame period = 4*PRESCALE cycles. Worst-case transfer-to-display latency is 4*PRESCALE cycles after the transfer edge.

Optional Feature:
- Macro: MACHINE_SCAN_DIM_EN.
- When defined:
  - Adds input port brightness[3:0].
  - Adds a free-running 4-bit pwm counter (reset 0, increments every cycle, wraps 15 -> 0).
  - The registered anode_n is the slot code when (brightness == 4'hF) || (pwm < brightness), and 4'b1111 otherwise. Brightness 0 is therefore always blank and brightness 15 is always on.
  - Digit fields and frame_start are unaffected.
- When undefined: the port and counter are absent, and anode_n is always the slot code.

Decomposition:
- Shared package machine_pkg holds:
  - DIGIT_W = 4, NUM_DIGITS = 4, STATE_W = 20.
  - Typedef digit_t (logic [3:0]).
  - Anode constants ANODE_SLOT0..3 and ANODE_BLANK.
  - Function slot_to_anode_n(slot) returning the active-low one-hot code.
- One natural sub-module: machine_scan_prescaler, containing the PRESCALE counter and tc output.
- Handshake, pending/active registers and slot logic stay in machine_scan.

Test Plan:
- Reset check (PRESCALE=4): hold rstn low for 3 cycles -> state = 20'h0000E, in_ready = 0, frame_start = 0 throughout. After release, in_ready = 1 on the next cycle.
- Slot rotation: free-run with no input -> anode_n sequence E, D, B, 7, each held 4 cycles, then E again. frame_start pulses once per 16 cycles, coincident with the first E cycle.
- Tear-free commit: transfer 16'h1234 mid-slot1 -> state digits stay 0000 until the wrap. At the wrap, state = 20'h1234E and in_ready returns to 1 on the same cycle.
- Back-pressure: hold in_valid=1 with 16'hABCD, then 16'h5678 before the wrap -> only ABCD is accepted. in_ready stays 0 until the wrap, then 5678 transfers and shows at the following wrap.
- Wrap-cycle transfer: assert in_valid with 16'h9999 exactly on the slot3 tc edge -> the transfer occurs, but state shows 9999 only one frame (16 cycles) later.
- Dimming (MACHINE_SCAN_DIM_EN, brightness = 4) -> anode_n equals the slot code for pwm 0..3 and 4'hF for pwm 4..15. brightness = 0 gives constant 4'hF; brightness = 15 gives no blank cycles.

Source files
------------

// File: rtl/machine_pkg.sv
// Shared widths, digit type and active-low anode codes for the display scan slice.
package machine_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned STATE_W    = 20;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam logic [3:0] ANODE_SLOT0 = 4'b1110;
  localparam logic [3:0] ANODE_SLOT1 = 4'b1101;
  localparam logic [3:0] ANODE_SLOT2 = 4'b1011;
  localparam logic [3:0] ANODE_SLOT3 = 4'b0111;
  localparam logic [3:0] ANODE_BLANK = 4'b1111;

  function automatic logic [3:0] slot_to_anode_n(input logic [1:0] slot);
    logic [3:0] anode_n;
    unique case (slot)
      2'd0: anode_n = ANODE_SLOT0;
      2'd1: anode_n = ANODE_SLOT1;
      2'd2: anode_n = ANODE_SLOT2;
      2'd3: anode_n = ANODE_SLOT3;
    endcase
    return anode_n;
  endfunction

endpackage

// File: rtl/machine_scan_prescaler.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 and flags the terminal count.
module machine_scan_prescaler
  import machine_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic i_clk,
  input  logic i_rstn,
  output logic o_tc
);

  if (PRESCALE < 2 || (longint'(1) << CNT_W) < longint'(PRESCALE)) begin : g_param_check
    $error("machine_scan_prescaler: PRESCALE must be >= 2 and fit in CNT_W bits");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == CNT_W'(PRESCALE - 1));
  assign o_tc = w_tc;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/machine_scan.sv
// Display-scan state generator: tear-free digit commit and rotating active-low anode select.
// Optional brightness PWM blanking is enabled by defining MACHINE_SCAN_DIM_EN.
module machine_scan
  import machine_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               system1000,
  input  logic               system1000_rstn,
`ifdef MACHINE_SCAN_DIM_EN
  input  logic [3:0]         brightness,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_digits,
  output logic               frame_start,
  output logic [STATE_W-1:0] state
);

  logic                        w_tc;
  logic                        w_wrap;
  logic                        w_xfer;
  logic [1:0]                  r_slot;
  logic [1:0]                  w_slot_d;
  digit_t [NUM_DIGITS-1:0]     r_active;
  digit_t [NUM_DIGITS-1:0]     w_active_d;
  digit_t [NUM_DIGITS-1:0]     r_pending;
  logic                        r_pend_v;
  logic [3:0]                  w_anode_d;
  logic [STATE_W-1:0]          r_state;
  logic                        r_frame_start;

  machine_scan_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .i_clk  (system1000),
    .i_rstn (system1000_rstn),
    .o_tc   (w_tc)
  );

  // Gating with reset keeps the upstream source from seeing ready while held in reset.
  assign in_ready = !r_pend_v && system1000_rstn;
  assign w_xfer   = in_valid && in_ready;
  assign w_wrap   = w_tc && (r_slot == 2'd3);

`ifdef MACHINE_SCAN_DIM_EN
  logic [3:0] r_pwm;

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      r_pwm <= 4'h0;
    end else begin
      r_pwm <= r_pwm + 4'h1;
    end
  end
`endif

  always_comb begin
    w_slot_d   = r_slot;
    w_active_d = r_active;
    if (w_tc) begin
      w_slot_d = r_slot + 2'd1;
    end
    if (w_wrap && r_pend_v) begin
      w_active_d = r_pending;
    end
    w_anode_d = slot_to_anode_n(w_slot_d);
`ifdef MACHINE_SCAN_DIM_EN
    if (!((brightness == 4'hF) || (r_pwm < brightness))) begin
      w_anode_d = ANODE_BLANK;
    end
`endif
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      r_slot        <= 2'd0;
      r_active      <= '0;
      r_pending     <= '0;
      r_pend_v      <= 1'b0;
      r_state       <= {16'h0000, ANODE_SLOT0};
      r_frame_start <= 1'b0;
    end else begin
      r_slot        <= w_slot_d;
      r_active      <= w_active_d;
      r_state       <= {w_active_d, w_anode_d};
      r_frame_start <= w_wrap;
      // A commit needs pend_v, which blocks ready, so transfer and commit never collide.
      if (w_xfer) begin
        r_pending <= in_digits;
        r_pend_v  <= 1'b1;
      end else if (w_wrap && r_pend_v) begin
        r_pend_v  <= 1'b0;
      end
    end
  end

  assign state       = r_state;
  assign frame_start = r_frame_start;

endmodule
